// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Brief    : UART transmitter state encoding, frame-format constants, helpers
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t c_ST_IDLE   = 3'd0;
    localparam uart_state_t c_ST_START  = 3'd1;
    localparam uart_state_t c_ST_DATA   = 3'd2;
    localparam uart_state_t c_ST_PARITY = 3'd3;
    localparam uart_state_t c_ST_STOP   = 3'd4;

    localparam logic [1:0] c_DBITS_5 = 2'b00;
    localparam logic [1:0] c_DBITS_6 = 2'b01;
    localparam logic [1:0] c_DBITS_7 = 2'b10;
    localparam logic [1:0] c_DBITS_8 = 2'b11;

    localparam logic c_PARITY_EVEN = 1'b0;
    localparam logic c_PARITY_ODD  = 1'b1;

    // Index of the final payload bit: 5 data bits end at index 4, 8 at index 7.
    function automatic logic [2:0] last_data_idx(input logic [1:0] dbn);
        return 3'd4 + {1'b0, dbn};
    endfunction

    function automatic logic [7:0] data_mask(input logic [1:0] dbn);
        logic [7:0] m;
        case (dbn)
            c_DBITS_5: m = 8'h1F;
            c_DBITS_6: m = 8'h3F;
            c_DBITS_7: m = 8'h7F;
            default:   m = 8'hFF;
        endcase
        return m;
    endfunction

    function automatic logic calc_parity(input logic [7:0] d,
                                         input logic [1:0] dbn,
                                         input logic       ptype);
        logic p;
        p = ^(d & data_mask(dbn));
        return (ptype == c_PARITY_ODD) ? ~p : p;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Brief    : Bit-period counter; one-cycle tick every CLKS_PER_BIT clocks
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [15:0] c_TERMINAL = 16'(CLKS_PER_BIT - 1);

    logic [15:0] r_cnt;
    logic        w_at_term;

    assign w_at_term = (r_cnt == c_TERMINAL);

    // Clear wins so a new frame always starts with a full first bit period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_at_term ? '0 : r_cnt + 16'd1;
        end
    end

    assign tick = enable && !clear && w_at_term;

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : UART transmitter, 5-8 data bits, optional parity, 1 or 2 stops
// Macro    : UART_TX_CTS_EN - gate frame acceptance on cts_n low
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_tx,
    input  logic [7:0] tx_data,
    input  logic [1:0] data_bit_num,
    input  logic       stop_bit_num,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       cts_n,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    uart_state_t r_state;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_data;
    logic [1:0]  r_dbn;
    logic        r_stop2;
    logic        r_par_en;
    logic        r_par_type;
    logic        r_tx;
    logic        r_busy;
    logic        r_done;

    uart_state_t w_state_nxt;
    logic [2:0]  w_bit_cnt_nxt;
    logic [2:0]  w_next_idx;
    logic        w_tx_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_accept;
    logic        w_cts_ok;
    logic        w_tick;
    logic        w_par_bit;

`ifdef UART_TX_CTS_EN
    assign w_cts_ok = ~cts_n;
`else
    // Flow control disabled: cts_n stays on the port but never gates a frame.
    assign w_cts_ok = 1'b1 | cts_n;
`endif

    assign w_accept   = (r_state == c_ST_IDLE) && start_tx && w_cts_ok;
    assign w_next_idx = r_bit_cnt + 3'd1;
    assign w_par_bit  = calc_parity(r_data, r_dbn, r_par_type);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_accept),
        .enable (r_busy),
        .tick   (w_tick)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_tx_nxt      = r_tx;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (w_accept) begin
                    w_state_nxt   = c_ST_START;
                    w_tx_nxt      = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_bit_cnt_nxt = 3'd0;
                end
            end
            c_ST_START: begin
                if (w_tick) begin
                    w_state_nxt   = c_ST_DATA;
                    w_tx_nxt      = r_data[0];
                    w_bit_cnt_nxt = 3'd0;
                end
            end
            c_ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == last_data_idx(r_dbn)) begin
                        w_bit_cnt_nxt = 3'd0;
                        if (r_par_en) begin
                            w_state_nxt = c_ST_PARITY;
                            w_tx_nxt    = w_par_bit;
                        end else begin
                            w_state_nxt = c_ST_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_cnt_nxt = w_next_idx;
                        w_tx_nxt      = r_data[w_next_idx];
                    end
                end
            end
            c_ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = c_ST_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            c_ST_STOP: begin
                // r_bit_cnt marks the first of two stop bits as already sent.
                if (w_tick) begin
                    if (r_stop2 && (r_bit_cnt == 3'd0)) begin
                        w_bit_cnt_nxt = 3'd1;
                    end else begin
                        w_state_nxt   = c_ST_IDLE;
                        w_bit_cnt_nxt = 3'd0;
                        w_busy_nxt    = 1'b0;
                        w_done_nxt    = 1'b1;
                        w_tx_nxt      = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt   = c_ST_IDLE;
                w_bit_cnt_nxt = 3'd0;
                w_tx_nxt      = 1'b1;
                w_busy_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_data     <= 8'h00;
            r_dbn      <= c_DBITS_8;
            r_stop2    <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_type <= c_PARITY_EVEN;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            if (w_accept) begin
                r_data     <= tx_data;
                r_dbn      <= data_bit_num;
                r_stop2    <= stop_bit_num;
                r_par_en   <= parity_en;
                r_par_type <= parity_type;
            end
        end
    end

    assign tx      = r_tx;
    assign busy    = r_busy;
    assign tx_done = r_done;

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Directed self-checking bench for uart_tx at CLKS_PER_BIT=16
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int BIT = 16;

`ifdef UART_TX_CTS_EN
    localparam logic CTS_GO = 1'b0;
`else
    localparam logic CTS_GO = 1'b1;
`endif

    logic       clk;
    logic       reset;
    logic       start_tx;
    logic [7:0] tx_data;
    logic [1:0] data_bit_num;
    logic       stop_bit_num;
    logic       parity_en;
    logic       parity_type;
    logic       cts_n;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx #(
        .CLKS_PER_BIT (BIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_tx     (start_tx),
        .tx_data      (tx_data),
        .data_bit_num (data_bit_num),
        .stop_bit_num (stop_bit_num),
        .parity_en    (parity_en),
        .parity_type  (parity_type),
        .cts_n        (cts_n),
        .tx           (tx),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // exp_bits[k] is the line level for bit period k of the frame.
    task automatic run_frame(input string tag, input logic [7:0] data, input logic [1:0] dbn,
                             input logic sbn, input logic pen, input logic ptype,
                             input logic [11:0] exp_bits, input int nbits,
                             input logic cts_mid, input logic hold_start,
                             input logic chained, input int abort_at);
        int len;
        int bad;
        len = nbits * BIT;
        bad = 0;
        if (!chained) @(negedge clk);
        tx_data      = data;
        data_bit_num = dbn;
        stop_bit_num = sbn;
        parity_en    = pen;
        parity_type  = ptype;
        cts_n        = CTS_GO;
        start_tx     = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= len + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check($sformatf("%s start edge tx", tag), tx, 0);
                check($sformatf("%s start busy", tag), busy, 1);
                tx_data      = ~data;
                data_bit_num = ~dbn;
                stop_bit_num = ~sbn;
                parity_en    = ~pen;
                parity_type  = ~ptype;
                if (!hold_start) start_tx = 1'b0;
            end
            if (!hold_start && c == 40) start_tx = 1'b1;
            if (!hold_start && c == 41) start_tx = 1'b0;
            if (cts_mid && c == 30) cts_n = 1'b1;
            if (c == abort_at) begin
                check($sformatf("%s pre-reset tx", tag), tx, exp_bits[(c-1)/BIT]);
                #2 reset = 1'b1;
                #1;
                check($sformatf("%s async reset tx", tag), tx, 1);
                check($sformatf("%s async reset busy", tag), busy, 0);
                check($sformatf("%s async reset done", tag), tx_done, 0);
                @(negedge clk);
                reset    = 1'b0;
                start_tx = 1'b0;
                repeat (3) @(negedge clk);
                check($sformatf("%s post-reset idle tx", tag), tx, 1);
                check($sformatf("%s post-reset idle busy", tag), busy, 0);
                return;
            end
            if (c <= len) begin
                if (tx !== exp_bits[(c-1)/BIT] || busy !== 1'b1 || tx_done !== 1'b0) bad++;
                if ((c - 1) % BIT == BIT / 2)
                    check($sformatf("%s bit%0d", tag, (c-1)/BIT), tx, exp_bits[(c-1)/BIT]);
            end else begin
                check($sformatf("%s done pulse", tag), tx_done, 1);
                check($sformatf("%s busy at done", tag), busy, 0);
                check($sformatf("%s idle tx at done", tag), tx, 1);
            end
        end
        check($sformatf("%s per-cycle errors", tag), bad, 0);
        if (!hold_start) begin
            @(negedge clk);
            check($sformatf("%s done single cycle", tag), tx_done, 0);
            check($sformatf("%s no queued frame", tag), busy, 0);
        end
    endtask

    initial begin
        int bad_cts;
        reset        = 1'b1;
        start_tx     = 1'b0;
        tx_data      = 8'h00;
        data_bit_num = 2'b11;
        stop_bit_num = 1'b0;
        parity_en    = 1'b0;
        parity_type  = 1'b0;
        cts_n        = 1'b1;
        #1;
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset done", tx_done, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle tx", tx, 1);
        check("idle busy", busy, 0);

        run_frame("a5_8n1", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 12'b1101001010,  10, 1'b0, 1'b0, 1'b0, 0);
        run_frame("07_7e2", 8'h07, 2'b10, 1'b1, 1'b1, 1'b0, 12'b11100001110, 11, 1'b0, 1'b0, 1'b0, 0);
        run_frame("ff_5o1", 8'hFF, 2'b00, 1'b0, 1'b1, 1'b1, 12'b10111110,     8, 1'b0, 1'b0, 1'b0, 0);
        run_frame("c3_6e1", 8'hC3, 2'b01, 1'b0, 1'b1, 1'b0, 12'b100000110,    9, 1'b0, 1'b1, 1'b0, 0);
        run_frame("a5_b2b", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 12'b1101001010,  10, 1'b0, 1'b0, 1'b1, 0);
        run_frame("a5_rst", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 12'b1101001010,  10, 1'b0, 1'b0, 1'b0, 70);
        run_frame("5a_8o1", 8'h5A, 2'b11, 1'b0, 1'b1, 1'b1, 12'b11010110100, 11, 1'b0, 1'b0, 1'b0, 0);

`ifdef UART_TX_CTS_EN
        @(negedge clk);
        cts_n    = 1'b1;
        start_tx = 1'b1;
        bad_cts  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad_cts++;
        end
        check("cts blocked", bad_cts, 0);
        run_frame("a5_cts", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 12'b1101001010, 10, 1'b1, 1'b0, 1'b1, 0);
`else
        bad_cts = 0;
        check("cts ignored count", bad_cts + n_fail, n_fail);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_tx
`default_nettype wire
